// File: rtl/clock_pkg.sv
// Shared types and constants for the clock display output path.
package clock_pkg;

    typedef enum logic [1:0] {
        STARTUP  = 2'd0,
        IDLE     = 2'd1,
        LAUNCH   = 2'd2,
        WAIT_ACK = 2'd3
    } seq_state_t;

    localparam int HOURS_W = 5;
    localparam int MIN_W   = 6;
    localparam int SEC_W   = 6;

    localparam logic [5:0] DP_SET_PATTERN = 6'b010100;

    // Counter width for a count limit, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/seq_timeout_counter.sv
// Loadable up-counter that stops at TERMINAL and flags it; used for the
// startup delay and the ack timeout.
module seq_timeout_counter #(
    parameter int WIDTH    = 4,
    parameter int TERMINAL = 15
) (
    input  logic i_clk,
    input  logic i_reset_n,
    input  logic i_load,
    input  logic i_run,
    output logic o_tc
);

    logic [WIDTH-1:0] r_count;
    logic             w_tc;

    assign w_tc = (r_count == WIDTH'(TERMINAL));
    assign o_tc = w_tc;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= '0;
        end else if (i_run && !w_tc) begin
            r_count <= r_count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/display_sequencer.sv
// Drives the MAX7219 wrapper: config after reset, then one data transfer per
// time change, with request coalescing, ack timeout and periodic config refresh.
//
//   state    | meaning
//   STARTUP  | post-reset settle delay, requests still queue
//   IDLE     | waiting for enable, wrapper idle and work to do
//   LAUNCH   | strobe cycle, snapshot already registered
//   WAIT_ACK | transaction in flight, ack timeout running
module display_sequencer
    import clock_pkg::*;
#(
    parameter int STARTUP_CYCLES  = 16,
    parameter int REFRESH_UPDATES = 60,
    parameter int ACK_TIMEOUT     = 4096
) (
    input  logic               i_clk,
    input  logic               i_reset_n,
    input  logic               i_en,
    input  logic               i_update_stb,
    input  logic               i_set_mode,
    input  logic [HOURS_W-1:0] i_hours,
    input  logic [MIN_W-1:0]   i_minutes,
    input  logic [SEC_W-1:0]   i_seconds,
    input  logic               i_disp_busy,
    input  logic               i_disp_ack,
    output logic               o_disp_stb,
    output logic               o_write_config,
    output logic [HOURS_W-1:0] o_hours,
    output logic [MIN_W-1:0]   o_minutes,
    output logic [SEC_W-1:0]   o_seconds,
    output logic [5:0]         o_dp,
    output logic               o_pending,
    output logic               o_timeout
);

    localparam int SU_W = cnt_width(STARTUP_CYCLES);
    localparam int AK_W = cnt_width(ACK_TIMEOUT);
    localparam int RF_W = cnt_width(REFRESH_UPDATES);

    seq_state_t         r_state;
    logic               r_disp_stb;
    logic               r_write_config;
    logic               r_pending;
    logic               r_need_config;
    logic               r_phase;
    logic [RF_W-1:0]    r_refresh_cnt;
    logic [HOURS_W-1:0] r_hours;
    logic [MIN_W-1:0]   r_minutes;
    logic [SEC_W-1:0]   r_seconds;
    logic [5:0]         r_dp;

    logic w_startup_done;
    logic w_ack_tc;
    logic w_launch;
    logic w_ack;
    logic w_timeout;
    logic w_cfg_ack;
    logic w_data_ack;
    logic w_refresh_hit;

    seq_timeout_counter #(.WIDTH(SU_W), .TERMINAL(STARTUP_CYCLES - 1)) u_startup_cnt (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .i_load    (1'b0),
        .i_run     (r_state == STARTUP),
        .o_tc      (w_startup_done)
    );

    seq_timeout_counter #(.WIDTH(AK_W), .TERMINAL(ACK_TIMEOUT - 1)) u_ack_cnt (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .i_load    (r_state == LAUNCH),
        .i_run     (r_state == WAIT_ACK),
        .o_tc      (w_ack_tc)
    );

    assign w_launch   = (r_state == IDLE) && i_en && !i_disp_busy && (r_need_config || r_pending);
    assign w_ack      = (r_state == WAIT_ACK) && i_disp_ack;
    assign w_timeout  = (r_state == WAIT_ACK) && !i_disp_ack && w_ack_tc;
    assign w_cfg_ack  = w_ack && r_write_config;
    assign w_data_ack = w_ack && !r_write_config;
    // The counter only ever holds up to REFRESH_UPDATES-1, so compare the next value.
    assign w_refresh_hit = (REFRESH_UPDATES != 0) && ((int'(r_refresh_cnt) + 1) == REFRESH_UPDATES);

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state <= STARTUP;
        end else begin
            case (r_state)
                STARTUP:  if (w_startup_done) r_state <= IDLE;
                IDLE:     if (w_launch) r_state <= LAUNCH;
                LAUNCH:   r_state <= WAIT_ACK;
                WAIT_ACK: if (w_ack || w_timeout) r_state <= IDLE;
                default:  r_state <= STARTUP;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_disp_stb     <= 1'b0;
            r_write_config <= 1'b0;
            r_hours        <= '0;
            r_minutes      <= '0;
            r_seconds      <= '0;
            r_dp           <= '0;
        end else begin
            r_disp_stb <= w_launch;
            if (w_launch) begin
                r_write_config <= r_need_config;
                r_hours        <= i_hours;
                r_minutes      <= i_minutes;
                r_seconds      <= i_seconds;
                r_dp           <= i_set_mode ? DP_SET_PATTERN : {1'b0, r_phase, 1'b0, r_phase, 2'b00};
            end else if (w_ack || w_timeout) begin
                r_write_config <= 1'b0;
            end
        end
    end

    // A request landing with the data ack survives it, so no time change is lost.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_pending     <= 1'b0;
            r_need_config <= 1'b1;
            r_phase       <= 1'b0;
            r_refresh_cnt <= '0;
        end else begin
            if (w_data_ack) begin
                r_pending <= i_update_stb;
            end else if (i_update_stb) begin
                r_pending <= 1'b1;
            end

            if (w_timeout) begin
                r_need_config <= 1'b1;
            end else if (w_cfg_ack) begin
                r_need_config <= 1'b0;
            end else if (w_data_ack && w_refresh_hit) begin
                r_need_config <= 1'b1;
            end

            if (w_data_ack) begin
                r_phase <= !r_phase;
            end

            if (w_cfg_ack) begin
                r_refresh_cnt <= '0;
            end else if (w_data_ack && (REFRESH_UPDATES != 0)) begin
                r_refresh_cnt <= w_refresh_hit ? '0 : r_refresh_cnt + RF_W'(1);
            end
        end
    end

    assign o_disp_stb     = r_disp_stb;
    assign o_write_config = r_write_config;
    assign o_hours        = r_hours;
    assign o_minutes      = r_minutes;
    assign o_seconds      = r_seconds;
    assign o_dp           = r_dp;
    assign o_pending      = r_pending;
    assign o_timeout      = w_timeout;

endmodule

// File: tb/tb_display_sequencer.sv
// Bench for display_sequencer: directed startup/coalescing/reset/timeout
// sequences, a table of data transfers, and a randomized run against a model.
module tb_display_sequencer;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic       upd;
    logic       set_mode;
    logic [4:0] hours;
    logic [5:0] minutes;
    logic [5:0] seconds;
    logic       busy;
    logic       ack;

    logic       d_stb;
    logic       d_cfg;
    logic [4:0] d_hours;
    logic [5:0] d_min;
    logic [5:0] d_sec;
    logic [5:0] d_dp;
    logic       d_pend;
    logic       d_tmo;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    display_sequencer #(
        .STARTUP_CYCLES  (16),
        .REFRESH_UPDATES (3),
        .ACK_TIMEOUT     (64)
    ) dut (
        .i_clk          (clk),
        .i_reset_n      (rst_n),
        .i_en           (en),
        .i_update_stb   (upd),
        .i_set_mode     (set_mode),
        .i_hours        (hours),
        .i_minutes      (minutes),
        .i_seconds      (seconds),
        .i_disp_busy    (busy),
        .i_disp_ack     (ack),
        .o_disp_stb     (d_stb),
        .o_write_config (d_cfg),
        .o_hours        (d_hours),
        .o_minutes      (d_min),
        .o_seconds      (d_sec),
        .o_dp           (d_dp),
        .o_pending      (d_pend),
        .o_timeout      (d_tmo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", n_pass, n_checks);
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        bit         upd;
        bit         set_mode;
        int         h;
        int         m;
        int         s;
        bit         exp_cfg;
        logic [5:0] exp_dp;
    } vec_t;

    vec_t vecs[7];

    function automatic logic [5:0] exp_dp(input bit sm, input bit ph);
        return sm ? 6'b010100 : {1'b0, ph, 1'b0, ph, 2'b00};
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic set_time(input int h, input int m, input int s);
        hours   = 5'(h);
        minutes = 6'(m);
        seconds = 6'(s);
    endtask

    task automatic pulse_upd();
        upd = 1'b1;
        tick();
        upd = 1'b0;
    endtask

    task automatic wait_stb(input string name, output int at);
        at = -1;
        for (int k = 0; k < 200; k++) begin
            tick();
            if (d_stb) begin
                at = cyc;
                break;
            end
        end
        if (at < 0) check({name, "_stb_seen"}, 0, 1);
    endtask

    // Ack is seen by the DUT on the edge that is d cycles after the strobe edge.
    task automatic ack_after(input int at, input int d);
        while (cyc < at + d - 1) tick();
        ack = 1'b1;
        tick();
        ack = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        upd = 1'b0; ack = 1'b0; busy = 1'b0; en = 1'b1; set_mode = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc = 0;
    endtask

    function automatic int all_outs();
        return int'({d_stb, d_cfg, d_hours, d_min, d_sec, d_dp, d_pend, d_tmo});
    endfunction

    int at;
    int nstb;
    // reference model state for the randomized run
    bit m_need, m_pend, m_phase, m_infl, m_cfg, m_hold;
    int m_cnt, m_stb, m_ack_at, n_data, n_cfg;
    logic [16:0] snap_time;
    logic [5:0]  snap_dp;

    initial begin
        vecs[0] = '{1, 1, 12, 34, 56, 0, 6'b010100};
        vecs[1] = '{1, 0,  1,  2,  3, 0, 6'b010100};
        vecs[2] = '{1, 0, 23, 59, 59, 0, 6'b000000};
        vecs[3] = '{0, 0,  7,  8,  9, 1, 6'b010100};
        vecs[4] = '{1, 1,  0,  0,  0, 0, 6'b010100};
        vecs[5] = '{1, 1, 10, 20, 30, 0, 6'b010100};
        vecs[6] = '{1, 0,  5,  6,  7, 0, 6'b010100};

        set_time(0, 0, 0);
        do_reset();
        check("reset_outputs", all_outs(), 0);

        // startup delay, early request, config first
        while (cyc < 4) tick();
        pulse_upd();
        check("startup_pending", int'(d_pend), 1);
        wait_stb("first_cfg", at);
        check("first_stb_cycle", at, 17);
        check("first_stb_cfg", int'(d_cfg), 1);

        // five requests during a long config transfer coalesce into one data transfer
        nstb = 0;
        for (int k = 1; k <= 50; k++) begin
            upd = ((k % 5) == 0) && (k <= 25);
            ack = (k == 50);
            tick();
            if (d_stb) nstb++;
        end
        upd = 1'b0; ack = 1'b0;
        check("cfg_xfer_no_stb", nstb, 0);
        check("cfg_xfer_pending", int'(d_pend), 1);
        wait_stb("coalesced", at);
        check("coalesced_cfg", int'(d_cfg), 0);
        ack_after(at, 3);
        nstb = 0;
        repeat (30) begin
            tick();
            if (d_stb) nstb++;
        end
        check("coalesced_single", nstb, 0);
        check("coalesced_pend_clear", int'(d_pend), 0);

        // asynchronous reset in WAIT_ACK
        set_time(9, 45, 30);
        pulse_upd();
        wait_stb("pre_reset", at);
        check("pre_reset_hours", int'(d_hours), 9);
        tick();
        tick();
        #3;
        rst_n = 1'b0;
        #1;
        check("async_reset_outputs", all_outs(), 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc = 0;
        wait_stb("restart", at);
        check("restart_stb_cycle", at, 17);
        check("restart_cfg", int'(d_cfg), 1);
        ack_after(at, 3);

        // table of transfers; every third data ack forces a config
        for (int i = 0; i < 7; i++) begin
            set_mode = vecs[i].set_mode;
            set_time(vecs[i].h, vecs[i].m, vecs[i].s);
            if (vecs[i].upd) pulse_upd();
            wait_stb($sformatf("vec%0d", i), at);
            check($sformatf("vec%0d_cfg", i), int'(d_cfg), int'(vecs[i].exp_cfg));
            check($sformatf("vec%0d_hours", i), int'(d_hours), vecs[i].h);
            check($sformatf("vec%0d_minutes", i), int'(d_min), vecs[i].m);
            check($sformatf("vec%0d_seconds", i), int'(d_sec), vecs[i].s);
            check($sformatf("vec%0d_dp", i), int'(d_dp), int'(vecs[i].exp_dp));
            ack_after(at, 3);
        end

        // disabled: requests queue, stray ack ignored, latest time used at launch
        en = 1'b0;
        set_mode = 1'b0;
        set_time(1, 1, 1);
        pulse_upd();
        nstb = 0;
        repeat (20) begin
            tick();
            if (d_stb) nstb++;
        end
        check("disabled_no_stb", nstb, 0);
        check("disabled_pending", int'(d_pend), 1);
        ack = 1'b1;
        tick();
        ack = 1'b0;
        check("stray_ack_pending", int'(d_pend), 1);
        set_time(2, 3, 4);
        en = 1'b1;
        wait_stb("enable_cfg", at);
        check("enable_cfg", int'(d_cfg), 1);
        check("enable_latest_hours", int'(d_hours), 2);
        ack_after(at, 3);
        wait_stb("enable_data", at);
        check("enable_data_cfg", int'(d_cfg), 0);
        check("enable_latest_min_sec", int'({d_min, d_sec}), int'({6'd3, 6'd4}));
        ack_after(at, 3);
        check("enable_pend_clear", int'(d_pend), 0);

        // ack withheld: timeout, then config, then the still-pending data
        set_time(11, 22, 33);
        pulse_upd();
        wait_stb("tmo_data", at);
        check("tmo_data_cfg", int'(d_cfg), 0);
        nstb = 0;
        for (int k = 1; k <= 65; k++) begin
            upd = (k == 10);
            tick();
            if (d_stb) nstb++;
            if (k == 63) check("tmo_early", int'(d_tmo), 0);
            if (k == 64) check("tmo_pulse", int'(d_tmo), 1);
            if (k == 65) check("tmo_single", int'(d_tmo), 0);
        end
        upd = 1'b0;
        check("tmo_no_stb", nstb, 0);
        check("tmo_pending_kept", int'(d_pend), 1);
        wait_stb("tmo_cfg", at);
        check("tmo_next_cfg", int'(d_cfg), 1);
        ack_after(at, 3);
        wait_stb("tmo_retry", at);
        check("tmo_retry_cfg", int'(d_cfg), 0);
        check("tmo_retry_hours", int'(d_hours), 11);
        ack_after(at, 3);
        check("tmo_retry_pend_clear", int'(d_pend), 0);

        // randomized run against the transaction-level model
        do_reset();
        check("rnd_reset_outputs", all_outs(), 0);
        m_need = 1; m_pend = 0; m_phase = 0; m_infl = 0; m_cfg = 0; m_hold = 0;
        m_cnt = 0; m_stb = 0; m_ack_at = 0; n_data = 0; n_cfg = 0;
        snap_time = '0; snap_dp = '0;
        for (int i = 0; i < 3000; i++) begin
            tick();
            if (m_infl && ack) begin
                if (m_cfg) begin
                    m_need = 0;
                    m_cnt  = 0;
                    if (upd) m_pend = 1;
                end else begin
                    m_pend  = upd;
                    m_phase = !m_phase;
                    m_cnt++;
                    if (m_cnt == 3) begin
                        m_need = 1;
                        m_cnt  = 0;
                    end
                end
                m_infl = 0;
            end else if (upd) begin
                m_pend = 1;
            end
            if (m_infl && m_hold && (cyc == m_stb + 65)) begin
                m_need = 1;
                m_infl = 0;
            end

            check("rnd_timeout", int'(d_tmo), int'(m_infl && m_hold && (cyc == m_stb + 64)));
            check("rnd_pending", int'(d_pend), int'(m_pend));
            if (d_stb) begin
                check("rnd_launch_allowed", int'((m_need || m_pend) && en && !busy && !m_infl), 1);
                check("rnd_cfg", int'(d_cfg), int'(m_need));
                check("rnd_snapshot", int'({d_hours, d_min, d_sec}), int'({hours, minutes, seconds}));
                check("rnd_dp", int'(d_dp), int'(exp_dp(set_mode, m_phase)));
                snap_time = {hours, minutes, seconds};
                snap_dp   = exp_dp(set_mode, m_phase);
                m_infl    = 1;
                m_cfg     = m_need;
                m_stb     = cyc;
                m_hold    = ($urandom_range(0, 9) == 0);
                m_ack_at  = cyc + int'($urandom_range(2, 12));
                if (m_cfg) n_cfg++;
                else n_data++;
            end else begin
                check("rnd_hold", int'({d_hours, d_min, d_sec, d_dp}), int'({snap_time, snap_dp}));
            end

            upd  = ($urandom_range(0, 5) == 0);
            ack  = m_infl ? (!m_hold && (cyc + 1 == m_ack_at)) : ($urandom_range(0, 19) == 0);
            busy = m_infl || ($urandom_range(0, 9) == 0);
            en   = ($urandom_range(0, 14) != 0);
            if ($urandom_range(0, 3) == 0) set_mode = !set_mode;
            hours   = 5'($urandom_range(0, 23));
            minutes = 6'($urandom_range(0, 59));
            seconds = 6'($urandom_range(0, 59));
        end
        check("rnd_data_progress", int'(n_data > 30), 1);
        check("rnd_cfg_progress", int'(n_cfg > 3), 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
